// File: rtl/csr_req_arbiter.sv
// Round-robin arbiter sharing one CSR request/response port between NumReq requesters.
// A granted read holds the arbiter until its response has been handed back to the owner.
module csr_req_arbiter #(
  parameter int NumReq       = 2,
  parameter int RegDataWidth = 32,
  parameter int RegAddrWidth = 32,
  parameter int IdxWidth     = $clog2(NumReq)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumReq*RegDataWidth-1:0] req_data_i,
  input  logic [NumReq*RegAddrWidth-1:0] req_addr_i,
  input  logic [NumReq-1:0]              req_write_i,
  input  logic [NumReq-1:0]              req_valid_i,
  output logic [NumReq-1:0]              req_ready_o,
  output logic [NumReq*RegDataWidth-1:0] rsp_data_o,
  output logic [NumReq-1:0]              rsp_valid_o,
  input  logic [NumReq-1:0]              rsp_ready_i,
  output logic [RegDataWidth-1:0]        csr_req_data_o,
  output logic [RegAddrWidth-1:0]        csr_req_addr_o,
  output logic                           csr_req_write_o,
  output logic                           csr_req_valid_o,
  input  logic                           csr_req_ready_i,
  input  logic [RegDataWidth-1:0]        csr_rsp_data_i,
  input  logic                           csr_rsp_valid_i,
  output logic                           csr_rsp_ready_o,
  output logic                           spurious_rsp_o
);

  typedef enum logic {IDLE, WAIT_RSP} state_t;

  state_t              state_reg, state_next;
  logic [IdxWidth-1:0] rr_ptr_reg, rr_ptr_next;
  logic [IdxWidth-1:0] owner_reg, owner_next;
  logic [IdxWidth-1:0] grant;

  logic [NumReq-1:0] hi_mask, hi_req, hi_first, lo_first, gnt_first;
  logic [NumReq-1:0] sel, own_sel;
  logic [IdxWidth-1:0]     idx_acc  [NumReq+1];
  logic [RegDataWidth-1:0] data_acc [NumReq+1];
  logic [RegAddrWidth-1:0] addr_acc [NumReq+1];
  logic any_valid, grant_write, owner_ready, is_idle, is_wait;

  assign is_idle   = (state_reg == IDLE);
  assign is_wait   = (state_reg == WAIT_RSP);
  assign any_valid = |req_valid_i;

  // Rotating priority: lowest valid index at or above rr_ptr, otherwise lowest valid overall.
  assign hi_req    = req_valid_i & hi_mask;
  assign hi_first  = hi_req & (~hi_req + NumReq'(1));
  assign lo_first  = req_valid_i & (~req_valid_i + NumReq'(1));
  assign gnt_first = (|hi_req) ? hi_first : lo_first;

  assign idx_acc[0]  = '0;
  assign data_acc[0] = '0;
  assign addr_acc[0] = '0;

  generate
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_req
      assign hi_mask[gi]     = (IdxWidth'(gi) >= rr_ptr_reg);
      assign idx_acc[gi+1]   = idx_acc[gi] | (gnt_first[gi] ? IdxWidth'(gi) : '0);
      assign sel[gi]         = (grant == IdxWidth'(gi));
      assign own_sel[gi]     = (owner_reg == IdxWidth'(gi));
      assign data_acc[gi+1]  = data_acc[gi]
                             | ({RegDataWidth{sel[gi]}} & req_data_i[gi*RegDataWidth +: RegDataWidth]);
      assign addr_acc[gi+1]  = addr_acc[gi]
                             | ({RegAddrWidth{sel[gi]}} & req_addr_i[gi*RegAddrWidth +: RegAddrWidth]);
      assign req_ready_o[gi] = is_idle & sel[gi] & csr_req_ready_i;
      assign rsp_valid_o[gi] = is_wait & own_sel[gi] & csr_rsp_valid_i;
    end
  endgenerate

  // With no valid requester the grant falls back to index 0, so the mux shows requester 0.
  assign grant           = idx_acc[NumReq];
  assign csr_req_data_o  = data_acc[NumReq];
  assign csr_req_addr_o  = addr_acc[NumReq];
  assign grant_write     = |(req_write_i & sel);
  assign csr_req_write_o = grant_write;
  assign owner_ready     = |(rsp_ready_i & own_sel);
  assign rsp_data_o      = {NumReq{csr_rsp_data_i}};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      owner_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      owner_reg  <= owner_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    rr_ptr_next     = rr_ptr_reg;
    owner_next      = owner_reg;
    csr_req_valid_o = 1'b0;
    csr_rsp_ready_o = 1'b1;
    spurious_rsp_o  = 1'b0;
    case (state_reg)
      IDLE: begin
        csr_req_valid_o = any_valid;
        // Nothing is outstanding here, so any response is drained and flagged.
        spurious_rsp_o  = csr_rsp_valid_i;
        if (any_valid && csr_req_ready_i) begin
          rr_ptr_next = (grant == IdxWidth'(NumReq - 1)) ? '0 : grant + IdxWidth'(1);
          if (!grant_write) begin
            owner_next = grant;
            state_next = WAIT_RSP;
          end
        end
      end
      WAIT_RSP: begin
        csr_rsp_ready_o = owner_ready;
        if (csr_rsp_valid_i && owner_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
